// File: rtl/instr_seq_ctrl_pkg.sv
// ctrl_pkg: sequencer state encoding, IR field layout and opcode constants.
// The ERR state exists only when CTRL_FETCH_TIMEOUT_EN is defined.
package ctrl_pkg;

`ifdef CTRL_FETCH_TIMEOUT_EN
    typedef enum logic [2:0] {IDLE, FETCH, DECODE, EXEC, WB, HALT, ERR} state_t;
`else
    typedef enum logic [2:0] {IDLE, FETCH, DECODE, EXEC, WB, HALT} state_t;
`endif

    // Bit ranges line up with the datapath's IR field macros.
    localparam int OPER_HI  = 31;
    localparam int OPER_LO  = 27;
    localparam int RDST_HI  = 26;
    localparam int RDST_LO  = 22;
    localparam int RSRC1_HI = 21;
    localparam int RSRC1_LO = 17;
    localparam int IMM_BIT  = 16;
    localparam int RSRC2_HI = 15;
    localparam int RSRC2_LO = 11;
    localparam int ISRC_HI  = 15;
    localparam int ISRC_LO  = 0;

    localparam logic [4:0] OP_NOP  = 5'h00;
    localparam logic [4:0] OP_MOV  = 5'h01;
    localparam logic [4:0] OP_ADD  = 5'h02;
    localparam logic [4:0] OP_HALT = 5'h1F;

endpackage

// File: rtl/instr_seq_ctrl_ir_field_decode.sv
// ir_field_decode: combinational split of the instruction register into control fields.
module ir_field_decode
    import ctrl_pkg::*;
(
    input  logic [31:0] ir,
    output logic [4:0]  oper_type,
    output logic [4:0]  rdst,
    output logic [4:0]  rsrc1,
    output logic        imm_mod,
    output logic [4:0]  rsrc2,
    output logic [15:0] isrc
);

    assign oper_type = ir[OPER_HI:OPER_LO];
    assign rdst      = ir[RDST_HI:RDST_LO];
    assign rsrc1     = ir[RSRC1_HI:RSRC1_LO];
    assign imm_mod   = ir[IMM_BIT];
    assign rsrc2     = ir[RSRC2_HI:RSRC2_LO];
    assign isrc      = ir[ISRC_HI:ISRC_LO];

endmodule

// File: rtl/instr_seq_ctrl.sv
// instr_seq_ctrl: multi-cycle fetch/decode/exec/writeback sequencer for the 32-bit core.
// Define CTRL_FETCH_TIMEOUT_EN to add the fetch-timeout counter and ERR state.
module instr_seq_ctrl
    import ctrl_pkg::*;
#(
    parameter int              PC_W          = 16,
    parameter logic [PC_W-1:0] START_PC      = '0,
    parameter int              FETCH_TIMEOUT = 255
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            start,
    output logic            imem_req,
    output logic [PC_W-1:0] imem_addr,
    input  logic            imem_ack,
    input  logic [31:0]     imem_rdata,
    output logic [31:0]     ir_q,
    output logic [4:0]      rf_raddr1,
    output logic [4:0]      rf_raddr2,
    output logic [4:0]      alu_op,
    output logic            alu_use_imm,
    output logic            alu_start,
    input  logic            alu_done,
    output logic            rf_we,
    output logic [4:0]      rf_waddr,
    output logic [PC_W-1:0] pc,
    output logic            busy,
    output logic            halted,
    output logic            err
);

    state_t state, state_nxt;
    logic exec_first;
    logic restart;
    logic [15:0] isrc_unused;

    ir_field_decode u_dec (
        .ir        (ir_q),
        .oper_type (alu_op),
        .rdst      (rf_waddr),
        .rsrc1     (rf_raddr1),
        .imm_mod   (alu_use_imm),
        .rsrc2     (rf_raddr2),
        .isrc      (isrc_unused)
    );

`ifdef CTRL_FETCH_TIMEOUT_EN
    localparam int TO_W = (FETCH_TIMEOUT > 255) ? $clog2(FETCH_TIMEOUT + 1) : 8;
    logic [TO_W-1:0] to_cnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            to_cnt <= '0;
        else
            to_cnt <= (state == FETCH && !imem_ack) ? to_cnt + TO_W'(1) : '0;
    end

    assign err = (state == ERR);
`else
    logic cfg_unused;
    assign cfg_unused = (FETCH_TIMEOUT != 0);
    assign err = 1'b0;
`endif

    always_comb begin
        state_nxt = state;
        restart   = 1'b0;
        unique case (state)
            IDLE:   if (start) state_nxt = FETCH;
            FETCH: begin
                if (imem_ack) state_nxt = DECODE;
`ifdef CTRL_FETCH_TIMEOUT_EN
                else if (to_cnt == TO_W'(FETCH_TIMEOUT - 1)) state_nxt = ERR;
`endif
            end
            DECODE: state_nxt = (alu_op == OP_HALT) ? HALT : EXEC;
            // alu_done alongside alu_start belongs to no operation of ours
            EXEC:   if (alu_done && !exec_first) state_nxt = WB;
            WB:     state_nxt = FETCH;
            HALT: begin
                state_nxt = start ? FETCH : HALT;
                restart   = start;
            end
`ifdef CTRL_FETCH_TIMEOUT_EN
            ERR: begin
                state_nxt = start ? FETCH : ERR;
                restart   = start;
            end
`endif
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            pc         <= START_PC;
            ir_q       <= '0;
            exec_first <= 1'b0;
        end else begin
            state      <= state_nxt;
            exec_first <= (state == DECODE);
            if (state == FETCH && imem_ack) begin
                ir_q <= imem_rdata;
                pc   <= pc + PC_W'(1);
            end else if (restart) begin
                pc <= START_PC;
            end
        end
    end

    assign imem_req  = (state == FETCH);
    assign imem_addr = pc;
    assign alu_start = (state == EXEC) && exec_first;
    assign rf_we     = (state == WB) && (alu_op != OP_NOP);
    assign busy      = (state == FETCH) || (state == DECODE) || (state == EXEC) || (state == WB);
    assign halted    = (state == HALT);

endmodule
